// File: rtl/sprite_draw_if.sv
// Requester-side bus of the sprite draw arbiter: per-sprite requests, cell data,
// and the one-hot grant/done replies.
interface sprite_draw_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*5-1:0]  old_x;
    logic [NUM_REQ*5-1:0]  old_y;
    logic [NUM_REQ*5-1:0]  new_x;
    logic [NUM_REQ*5-1:0]  new_y;
    logic [NUM_REQ*25-1:0] shape;
    logic [NUM_REQ*3-1:0]  colour;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done;

    modport master (output req, old_x, old_y, new_x, new_y, shape, colour,
                    input  grant, done);
    modport slave  (input  req, old_x, old_y, new_x, new_y, shape, colour,
                    output grant, done);
endinterface

// File: rtl/sprite_draw_arbiter.sv
// Round-robin owner of the 5x5-tile pixel engine: erases a sprite's old cell,
// paints its new cell through the shape mask, then pulses done for that sprite.
module sprite_draw_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TILE_X_MAX = 31,
    parameter int TILE_Y_MAX = 23
) (
    input  logic         clock,
    input  logic         reset,
    sprite_draw_if.slave bus,
    output logic         busy,
    output logic [7:0]   x_out,
    output logic [6:0]   y_out,
    output logic [2:0]   col_out,
    output logic         plot
);
    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_ERASE = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick;
    logic               found;
    int                 idx;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [2:0]         row, col, nxt_row, nxt_col;
    logic               last_px;
    logic [4:0]         ox_r, oy_r, nx_r, ny_r;
    logic [24:0]        shape_r;
    logic [2:0]         colour_r;

    assign bus.grant = grant_q;
    assign bus.done  = done_q;

    function automatic logic off_grid(input logic [4:0] tx, input logic [4:0] ty);
        return (int'(tx) > TILE_X_MAX) || (int'(ty) > TILE_Y_MAX);
    endfunction

    function automatic logic [7:0] tile_px_x(input logic [4:0] t, input logic [2:0] c);
        return ({3'b000, t} << 2) + {3'b000, t} + {5'b00000, c};
    endfunction

    function automatic logic [6:0] tile_px_y(input logic [4:0] t, input logic [2:0] r);
        return ({2'b00, t} << 2) + {2'b00, t} + {4'b0000, r};
    endfunction

    // Bit 24 is the top-left pixel, so the mask is walked from the MSB down.
    function automatic logic [2:0] shape_col(input logic [24:0] shp, input logic [2:0] clr,
                                             input logic [2:0] r, input logic [2:0] c);
        logic [4:0] bi;
        bi = 5'd24 - ({2'b00, r} * 5'd5 + {2'b00, c});
        return shp[bi] ? clr : 3'b000;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        last_px = (row == 3'd4) && (col == 3'd4);
        if (col == 3'd4) begin
            nxt_col = 3'd0;
            nxt_row = row + 3'd1;
        end else begin
            nxt_col = col + 3'd1;
            nxt_row = row;
        end
    end

    // Cell data is captured on the arbitration edge; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && found) begin
            ox_r     <= bus.old_x[5*int'(pick) +: 5];
            oy_r     <= bus.old_y[5*int'(pick) +: 5];
            nx_r     <= bus.new_x[5*int'(pick) +: 5];
            ny_r     <= bus.new_y[5*int'(pick) +: 5];
            shape_r  <= bus.shape[25*int'(pick) +: 25];
            colour_r <= bus.colour[3*int'(pick) +: 3];
        end
    end

    // Pixel outputs are registered for the state being entered, so plot is high
    // exactly during the ERASE/DRAW cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy    <= 1'b0;
            plot    <= 1'b0;
            x_out   <= '0;
            y_out   <= '0;
            col_out <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state   <= S_LATCH;
                        grant_q <= NUM_REQ'(1) << pick;
                        busy    <= 1'b1;
                        ptr     <= wrap_inc(pick);
                    end
                end
                S_LATCH: begin
                    if (off_grid(ox_r, oy_r) || off_grid(nx_r, ny_r)) begin
                        state  <= S_DONE;
                        done_q <= grant_q;
                    end else begin
                        row  <= 3'd0;
                        col  <= 3'd0;
                        plot <= 1'b1;
                        if (ox_r == nx_r && oy_r == ny_r) begin
                            state   <= S_DRAW;
                            x_out   <= tile_px_x(nx_r, 3'd0);
                            y_out   <= tile_px_y(ny_r, 3'd0);
                            col_out <= shape_col(shape_r, colour_r, 3'd0, 3'd0);
                        end else begin
                            state   <= S_ERASE;
                            x_out   <= tile_px_x(ox_r, 3'd0);
                            y_out   <= tile_px_y(oy_r, 3'd0);
                            col_out <= 3'b000;
                        end
                    end
                end
                S_ERASE: begin
                    if (last_px) begin
                        state   <= S_DRAW;
                        row     <= 3'd0;
                        col     <= 3'd0;
                        x_out   <= tile_px_x(nx_r, 3'd0);
                        y_out   <= tile_px_y(ny_r, 3'd0);
                        col_out <= shape_col(shape_r, colour_r, 3'd0, 3'd0);
                    end else begin
                        row     <= nxt_row;
                        col     <= nxt_col;
                        x_out   <= tile_px_x(ox_r, nxt_col);
                        y_out   <= tile_px_y(oy_r, nxt_row);
                        col_out <= 3'b000;
                    end
                end
                S_DRAW: begin
                    if (last_px) begin
                        state   <= S_DONE;
                        done_q  <= grant_q;
                        plot    <= 1'b0;
                        x_out   <= '0;
                        y_out   <= '0;
                        col_out <= '0;
                    end else begin
                        row     <= nxt_row;
                        col     <= nxt_col;
                        x_out   <= tile_px_x(nx_r, nxt_col);
                        y_out   <= tile_px_y(ny_r, nxt_row);
                        col_out <= shape_col(shape_r, colour_r, nxt_row, nxt_col);
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    grant_q <= '0;
                    done_q  <= '0;
                    busy    <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Bench for sprite_draw_arbiter: a transaction-level model predicts every output
// cycle; directed scenarios pin the model with hand-computed values.
module tb_sprite_draw_arbiter;
    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       busy, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] col_out;

    sprite_draw_if #(.NUM_REQ(N)) bus ();

    sprite_draw_arbiter #(.NUM_REQ(N)) dut (
        .clock(clock), .reset(reset), .bus(bus), .busy(busy),
        .x_out(x_out), .y_out(y_out), .col_out(col_out), .plot(plot)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic         busy;
        logic         plot;
        logic [7:0]   x;
        logic [6:0]   y;
        logic [2:0]   col;
    } exp_t;

    exp_t        q[$];
    int          mptr = 0;
    int          gnt_log[$];
    int          gnt_cyc[$];
    logic [17:0] plot_log[$];
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] last_done = '0;

    function automatic logic [27:0] pack(input exp_t e);
        return {e.grant, e.done, e.busy, e.plot, e.x, e.y, e.col};
    endfunction

    // Expand one granted request into its complete per-cycle output sequence.
    task automatic push_txn(input int g);
        int ox, oy, nx, ny;
        logic [24:0] sh;
        logic [2:0]  co;
        exp_t e;
        ox = int'(bus.old_x[g*5 +: 5]);
        oy = int'(bus.old_y[g*5 +: 5]);
        nx = int'(bus.new_x[g*5 +: 5]);
        ny = int'(bus.new_y[g*5 +: 5]);
        sh = bus.shape[g*25 +: 25];
        co = bus.colour[g*3 +: 3];
        e = '{grant: N'(1) << g, done: '0, busy: 1'b1, plot: 1'b0, x: '0, y: '0, col: '0};
        q.push_back(e);
        if (!(ox > 31 || oy > 23 || nx > 31 || ny > 23)) begin
            e.plot = 1'b1;
            if (!(ox == nx && oy == ny)) begin
                for (int p = 0; p < 25; p++) begin
                    e.x = 8'(ox * 5 + p % 5);
                    e.y = 7'(oy * 5 + p / 5);
                    e.col = 3'b000;
                    q.push_back(e);
                end
            end
            for (int p = 0; p < 25; p++) begin
                e.x = 8'(nx * 5 + p % 5);
                e.y = 7'(ny * 5 + p / 5);
                e.col = sh[24 - p] ? co : 3'b000;
                q.push_back(e);
            end
        end
        e = '{grant: N'(1) << g, done: N'(1) << g, busy: 1'b1, plot: 1'b0, x: '0, y: '0, col: '0};
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t cur;
        logic [27:0] act;
        logic idle_cyc;
        int g;
        act = {bus.grant, bus.done, busy, plot, x_out, y_out, col_out};
        cur = '{grant: '0, done: '0, busy: 1'b0, plot: 1'b0, x: '0, y: '0, col: '0};
        if (reset) begin
            q.delete();
            mptr = 0;
            chk("reset_outputs", 32'(act), 32'(pack(cur)));
        end else begin
            idle_cyc = (q.size() == 0);
            if (!idle_cyc) cur = q.pop_front();
            chk("cycle_outputs", 32'(act), 32'(pack(cur)));
            if (idle_cyc && bus.req != '0) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && bus.req[(mptr + k) % N]) g = (mptr + k) % N;
                mptr = (g + 1) % N;
                push_txn(g);
            end
            if (plot) plot_log.push_back({x_out, y_out, col_out});
        end
        if (bus.grant != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++)
                if (bus.grant[k]) begin
                    gnt_log.push_back(k);
                    gnt_cyc.push_back(cyc);
                end
        end
        prev_grant = bus.grant;
        last_done  = bus.done;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_src(input int i, input int ox, input int oy, input int nx, input int ny,
                           input logic [24:0] sh, input logic [2:0] co);
        bus.old_x[i*5 +: 5]  = 5'(ox);
        bus.old_y[i*5 +: 5]  = 5'(oy);
        bus.new_x[i*5 +: 5]  = 5'(nx);
        bus.new_y[i*5 +: 5]  = 5'(ny);
        bus.shape[i*25 +: 25] = sh;
        bus.colour[i*3 +: 3] = co;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int i, input int lim, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < lim; k++) begin
            tick();
            if (bus.done[i]) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) begin
            tests++;
            fails++;
            $display("FAIL wait_done_%0d: no done within %0d cycles, expected a pulse", i, lim);
        end
    endtask

    task automatic wait_idle(input int lim);
        int ok;
        ok = 0;
        for (int k = 0; k < lim; k++) begin
            tick();
            if (!busy && q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", lim);
        end
    endtask

    initial begin
        int t0, d0, d1, ox, oy;
        logic [17:0] pl;
        bus.req = '0; bus.old_x = '0; bus.old_y = '0; bus.new_x = '0; bus.new_y = '0;
        bus.shape = '0; bus.colour = '0;
        tick(); tick(); tick();
        reset = 1'b0;

        // Scenario 1: erase (2,3), draw (3,3) solid colour 110.
        set_src(0, 2, 3, 3, 3, 25'h1FFFFFF, 3'b110);
        plot_log.delete();
        tick();
        bus.req = 4'b0001;
        t0 = cyc;
        wait_done(0, 100, d0);
        bus.req = '0;
        chk("t1_done_latency", 32'(d0 - t0), 52);
        chk("t1_plot_count", 32'(plot_log.size()), 50);
        pl = plot_log.size() > 49 ? plot_log[0] : 18'h0;
        chk("t1_first_erase_px", 32'(pl), 32'({8'd10, 7'd15, 3'b000}));
        pl = plot_log.size() > 49 ? plot_log[25] : 18'h0;
        chk("t1_first_draw_px", 32'(pl), 32'({8'd15, 7'd15, 3'b110}));
        pl = plot_log.size() > 49 ? plot_log[49] : 18'h0;
        chk("t1_last_draw_px", 32'(pl), 32'({8'd19, 7'd19, 3'b110}));
        wait_idle(10);

        // Scenario 2: all four requesting continuously from reset.
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, i, i, i + 1, i, 25'($urandom), 3'(i + 1));
        gnt_log.delete(); gnt_cyc.delete();
        bus.req = 4'b1111;
        for (int k = 0; k < 400 && gnt_log.size() < 5; k++) tick();
        bus.req = '0;
        chk("t2_grant_count", 32'(gnt_log.size()), 5);
        if (gnt_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("t2_grant_order", 32'(gnt_log[k]), 32'(k % 4));
            for (int k = 1; k < 5; k++) chk("t2_grant_spacing", 32'(gnt_cyc[k] - gnt_cyc[k-1]), 53);
        end
        wait_idle(100);

        // Scenario 3: erase skipped, single top-left pixel lit.
        set_src(0, 0, 0, 0, 0, 25'h1000000, 3'b011);
        plot_log.delete();
        bus.req = 4'b0001;
        t0 = cyc;
        wait_done(0, 100, d0);
        bus.req = '0;
        chk("t3_done_latency", 32'(d0 - t0), 27);
        chk("t3_plot_count", 32'(plot_log.size()), 25);
        if (plot_log.size() == 25) begin
            chk("t3_px0", 32'(plot_log[0]), 32'({8'd0, 7'd0, 3'b011}));
            chk("t3_px1", 32'(plot_log[1]), 32'({8'd1, 7'd0, 3'b000}));
            chk("t3_px24", 32'(plot_log[24]), 32'({8'd4, 7'd4, 3'b000}));
        end
        wait_idle(10);

        // Scenario 4: off-grid row on requester 0, requester 1 waits behind it.
        do_reset();
        set_src(0, 1, 1, 2, 24, 25'h1FFFFFF, 3'b111);
        set_src(1, 5, 6, 7, 8, 25'h0AAAAAA, 3'b101);
        plot_log.delete();
        bus.req = 4'b0011;
        t0 = cyc;
        wait_done(0, 20, d0);
        bus.req[0] = 1'b0;
        chk("t4_offgrid_done_latency", 32'(d0 - t0), 2);
        chk("t4_offgrid_no_plot", 32'(plot_log.size()), 0);
        wait_done(1, 100, d1);
        bus.req[1] = 1'b0;
        chk("t4_next_done_latency", 32'(d1 - t0), 55);
        pl = plot_log.size() > 0 ? plot_log[0] : 18'h0;
        chk("t4_next_first_px", 32'(pl), 32'({8'd25, 7'd30, 3'b000}));
        wait_idle(10);

        // Scenario 5: reset lands mid-draw; pointer restarts at requester 0.
        do_reset();
        set_src(1, 3, 4, 6, 7, 25'h1FFFFFF, 3'b010);
        bus.req = 4'b0010;
        t0 = cyc;
        while (cyc < t0 + 37) tick();
        chk("t5_px10_before_reset", 32'({plot, x_out, y_out}), 32'({1'b1, 8'd30, 7'd37}));
        reset = 1'b1;
        bus.req = '0;
        #1;
        chk("t5_async_clear", 32'({plot, busy, bus.grant, bus.done}), 0);
        set_src(2, 9, 9, 10, 9, 25'h1555555, 3'b001);
        bus.req = 4'b0100;
        tick(); tick();
        gnt_log.delete();
        reset = 1'b0;
        wait_done(2, 100, d0);
        bus.req = '0;
        chk("t5_first_grant", 32'(gnt_log.size() > 0 ? gnt_log[0] : 99), 2);
        wait_idle(10);
        tick();
        reset = 1'b1;
        set_src(0, 4, 4, 4, 5, 25'h0F0F0F0, 3'b100);
        bus.req = 4'b0101;
        tick(); tick();
        gnt_log.delete();
        reset = 1'b0;
        wait_done(0, 100, d0);
        bus.req[0] = 1'b0;
        wait_done(2, 100, d1);
        bus.req[2] = 1'b0;
        chk("t5_ptr_reset_grant", 32'(gnt_log.size() > 1 ? gnt_log[0] : 99), 0);
        chk("t5_second_grant", 32'(gnt_log.size() > 1 ? gnt_log[1] : 99), 2);
        wait_idle(10);

        // Scenario 6: inputs disturbed during the erase.
        set_src(3, 10, 10, 12, 11, 25'h1FFFFFF, 3'b111);
        plot_log.delete();
        bus.req = 4'b1000;
        t0 = cyc;
        while (cyc < t0 + 5) tick();
        bus.new_x[15 +: 5] = 5'd20;
        bus.shape[75 +: 25] = 25'h0;
        bus.colour[9 +: 3] = 3'b001;
        wait_done(3, 100, d0);
        bus.req = '0;
        pl = plot_log.size() > 25 ? plot_log[25] : 18'h0;
        chk("t6_latched_draw_px", 32'(pl), 32'({8'd60, 7'd55, 3'b111}));
        wait_idle(10);

        // Randomised traffic: requests come and go, data churns, some cells off-grid.
        plot_log.delete();
        for (int c = 0; c < 2500; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        ox = int'($urandom_range(0, 31));
                        oy = int'($urandom_range(0, 24));
                        if ($urandom_range(0, 3) == 0)
                            set_src(i, ox, oy, ox, oy, 25'($urandom), 3'($urandom));
                        else
                            set_src(i, ox, oy, int'($urandom_range(0, 31)), int'($urandom_range(0, 24)),
                                    25'($urandom), 3'($urandom));
                        bus.req[i] = 1'b1;
                    end
                end else if (last_done[i] && $urandom_range(0, 3) != 0) begin
                    bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 199) == 0) begin
                    bus.req[i] = 1'b0;
                end
                if ($urandom_range(0, 15) == 0) bus.shape[i*25 +: 25] = 25'($urandom);
            end
        end
        bus.req = '0;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
